// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / run-control unit.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_STOPPED = 2'd3
  } state_t;

  // Forward select value meaning "take operand from the register file".
  localparam int FWD_RF = 0;

  localparam int REG_WIDTH_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority forwarding comparator: picks the nearest post-EX stage writing the
// source register, or the register file when no stage matches.
module pipe_hazard_ctrl_fwd_select
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int FWD_STAGES = 2,
  parameter int SEL_WIDTH  = 2
) (
  input  logic [REG_WIDTH-1:0]            i_src_reg,
  input  logic [FWD_STAGES-1:0]           i_wr_en,
  input  logic [FWD_STAGES*REG_WIDTH-1:0] i_wr_reg,
  output logic [SEL_WIDTH-1:0]            o_sel
);

  logic [FWD_STAGES-1:0] w_match;

  generate
    for (genvar gi = 0; gi < FWD_STAGES; gi++) begin : g_match
      assign w_match[gi] = i_wr_en[gi] &&
                           (i_wr_reg[gi*REG_WIDTH +: REG_WIDTH] == i_src_reg);
    end
  endgenerate

  // Scan from the farthest stage down so the nearest match overwrites the rest.
  always_comb begin
    o_sel = SEL_WIDTH'(FWD_RF);
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (w_match[k]) o_sel = SEL_WIDTH'(k + 1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and run-control unit: operand forwarding, load-use bubbles, branch and
// jump flushes, a start/stop FSM with a drain phase, and a stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_WIDTH    = REG_WIDTH_DEF,
  parameter int FWD_STAGES   = 2,
  parameter int SEL_WIDTH    = 2,
  parameter int LOAD_LAT     = 1,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop_req,
  input  logic [REG_WIDTH-1:0]            rsD,
  input  logic [REG_WIDTH-1:0]            rtD,
  input  logic                            use_rsD,
  input  logic                            use_rtD,
  input  logic [REG_WIDTH-1:0]            rsE,
  input  logic [REG_WIDTH-1:0]            rtE,
  input  logic                            MemReadE,
  input  logic [REG_WIDTH-1:0]            WriteRegE,
  input  logic [FWD_STAGES-1:0]           fwd_wr_en,
  input  logic [FWD_STAGES*REG_WIDTH-1:0] fwd_wr_reg,
  input  logic                            PCSrc,
  input  logic                            jump,
  output logic [SEL_WIDTH-1:0]            alu_src1,
  output logic [SEL_WIDTH-1:0]            alu_src2,
  output logic                            pcstall,
  output logic                            IF_IDstall,
  output logic                            flushIF_ID,
  output logic                            flushID_EX,
  output logic                            flushEX_MEM,
  output logic                            running,
  output logic                            stopped,
  output logic [CNT_WIDTH-1:0]            stall_count
);

  state_t               r_state, w_state_next;
  logic [2:0]           r_bub, w_bub_next;
  logic [3:0]           r_drain, w_drain_next;
  logic [CNT_WIDTH-1:0] r_stall_cnt, w_stall_cnt_next;

  logic w_in_run;
  logic w_detect;
  logic w_lu_stall;

  pipe_hazard_ctrl_fwd_select #(
    .REG_WIDTH (REG_WIDTH),
    .FWD_STAGES(FWD_STAGES),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_fwd_rs (
    .i_src_reg(rsE),
    .i_wr_en  (fwd_wr_en),
    .i_wr_reg (fwd_wr_reg),
    .o_sel    (alu_src1)
  );

  pipe_hazard_ctrl_fwd_select #(
    .REG_WIDTH (REG_WIDTH),
    .FWD_STAGES(FWD_STAGES),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_fwd_rt (
    .i_src_reg(rtE),
    .i_wr_en  (fwd_wr_en),
    .i_wr_reg (fwd_wr_reg),
    .o_sel    (alu_src2)
  );

  assign w_in_run = (r_state == ST_RUN);
  assign w_detect = MemReadE && ((use_rsD && (WriteRegE == rsD)) ||
                                 (use_rtD && (WriteRegE == rtD)));
  // A taken branch squashes the dependent instruction, so it cancels the stall.
  assign w_lu_stall = w_in_run && !PCSrc && ((r_bub != '0) || w_detect);

  always_comb begin
    w_state_next     = r_state;
    w_bub_next       = '0;
    w_drain_next     = r_drain;
    w_stall_cnt_next = r_stall_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next     = ST_RUN;
          w_stall_cnt_next = '0;
        end
      end
      ST_RUN: begin
        if (PCSrc)               w_bub_next = '0;
        else if (r_bub != '0)    w_bub_next = r_bub - 3'd1;
        else if (w_detect)       w_bub_next = 3'(LOAD_LAT - 1);
        if (w_lu_stall && (r_stall_cnt != '1))
          w_stall_cnt_next = r_stall_cnt + 1'b1;
        if (stop_req && !PCSrc && !w_lu_stall) begin
          w_state_next = ST_DRAIN;
          w_drain_next = 4'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (r_drain == '0) w_state_next = ST_STOPPED;
        else               w_drain_next = r_drain - 4'd1;
      end
      ST_STOPPED: begin
        if (start) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pcstall     = 1'b0;
    IF_IDstall  = 1'b0;
    flushIF_ID  = 1'b0;
    flushID_EX  = 1'b0;
    flushEX_MEM = 1'b0;
    running     = w_in_run;
    stopped     = (r_state == ST_STOPPED);
    case (r_state)
      ST_IDLE, ST_STOPPED: begin
        pcstall    = 1'b1;
        IF_IDstall = 1'b1;
        flushID_EX = 1'b1;
      end
      ST_DRAIN: begin
        pcstall    = 1'b1;
        flushIF_ID = 1'b1;
        flushID_EX = 1'b1;
      end
      default: begin
        if (PCSrc) begin
          flushIF_ID  = 1'b1;
          flushID_EX  = 1'b1;
          flushEX_MEM = 1'b1;
        end else if (w_lu_stall) begin
          pcstall    = 1'b1;
          IF_IDstall = 1'b1;
          flushID_EX = 1'b1;
        end else if (jump) begin
          flushIF_ID = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_bub       <= '0;
      r_drain     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bub       <= w_bub_next;
      r_drain     <= w_drain_next;
      r_stall_cnt <= w_stall_cnt_next;
    end
  end

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with FWD_STAGES=3, LOAD_LAT=2, DRAIN_CYCLES=4.
module tb_pipe_hazard_ctrl;

  localparam int RW = 4;
  localparam int FS = 3;
  localparam int SW = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, stop_req;
  logic [RW-1:0] rsD, rtD, rsE, rtE, WriteRegE;
  logic          use_rsD, use_rtD, MemReadE, PCSrc, jump;
  logic [FS-1:0]    fwd_wr_en;
  logic [FS*RW-1:0] fwd_wr_reg;
  logic [SW-1:0] alu_src1, alu_src2;
  logic pcstall, IF_IDstall, flushIF_ID, flushID_EX, flushEX_MEM, running, stopped;
  logic [CW-1:0] stall_count;
  logic [6:0]    ctrl;

  int total = 0;
  int bad   = 0;

  // {pcstall, IF_IDstall, flushIF_ID, flushID_EX, flushEX_MEM, running, stopped}
  localparam logic [6:0] C_IDLE    = 7'b1101000;
  localparam logic [6:0] C_STOPPED = 7'b1101001;
  localparam logic [6:0] C_RUN     = 7'b0000010;
  localparam logic [6:0] C_STALL   = 7'b1101010;
  localparam logic [6:0] C_BRANCH  = 7'b0011110;
  localparam logic [6:0] C_JUMP    = 7'b0010010;
  localparam logic [6:0] C_DRAIN   = 7'b1011000;

  assign ctrl = {pcstall, IF_IDstall, flushIF_ID, flushID_EX, flushEX_MEM, running, stopped};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_WIDTH(RW), .FWD_STAGES(FS), .SEL_WIDTH(SW),
    .LOAD_LAT(2), .DRAIN_CYCLES(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .rsD(rsD), .rtD(rtD), .use_rsD(use_rsD), .use_rtD(use_rtD),
    .rsE(rsE), .rtE(rtE), .MemReadE(MemReadE), .WriteRegE(WriteRegE),
    .fwd_wr_en(fwd_wr_en), .fwd_wr_reg(fwd_wr_reg),
    .PCSrc(PCSrc), .jump(jump),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .pcstall(pcstall), .IF_IDstall(IF_IDstall),
    .flushIF_ID(flushIF_ID), .flushID_EX(flushID_EX), .flushEX_MEM(flushEX_MEM),
    .running(running), .stopped(stopped), .stall_count(stall_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    start = 0; stop_req = 0; rsD = 0; rtD = 0; use_rsD = 0; use_rtD = 0;
    rsE = 0; rtE = 0; MemReadE = 0; WriteRegE = 0; PCSrc = 0; jump = 0;
    fwd_wr_en = '0; fwd_wr_reg = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 0;
    tick(); tick();
    total++; if (ctrl !== C_IDLE) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_IDLE); end
    total++; if (stall_count !== 16'd0) begin bad++;
      $display("FAIL reset_cnt got=%0d exp=0", stall_count); end
    $display("test_reset: ctrl=%b stall_count=%0d", ctrl, stall_count);
  endtask

  task automatic test_start;
    rst = 1;
    tick();
    total++; if (ctrl !== C_IDLE) begin bad++;
      $display("FAIL idle_hold got=%b exp=%b", ctrl, C_IDLE); end
    start = 1; #1;
    total++; if (pcstall !== 1'b1) begin bad++;
      $display("FAIL start_same_cycle pcstall got=%b exp=1", pcstall); end
    tick(); start = 0; #1;
    total++; if (ctrl !== C_RUN) begin bad++;
      $display("FAIL start_run got=%b exp=%b", ctrl, C_RUN); end
    total++; if (stall_count !== 16'd0) begin bad++;
      $display("FAIL start_cnt got=%0d exp=0", stall_count); end
    $display("test_start: ctrl=%b stall_count=%0d", ctrl, stall_count);
  endtask

  task automatic test_forwarding;
    rsE = 4'd5; fwd_wr_en = 3'b110; fwd_wr_reg = {4'd5, 4'd5, 4'd2}; #1;
    total++; if (alu_src1 !== 2'd2) begin bad++;
      $display("FAIL fwd_stage1 got=%0d exp=2", alu_src1); end
    fwd_wr_en = 3'b111; fwd_wr_reg = {4'd5, 4'd5, 4'd5}; #1;
    total++; if (alu_src1 !== 2'd1) begin bad++;
      $display("FAIL fwd_nearest got=%0d exp=1", alu_src1); end
    rsE = 4'd9; rtE = 4'd7; fwd_wr_reg = {4'd7, 4'd3, 4'd1}; #1;
    total++; if (alu_src1 !== 2'd0) begin bad++;
      $display("FAIL fwd_none got=%0d exp=0", alu_src1); end
    total++; if (alu_src2 !== 2'd3) begin bad++;
      $display("FAIL fwd_rt_far got=%0d exp=3", alu_src2); end
    fwd_wr_en = 3'b011; #1;
    total++; if (alu_src2 !== 2'd0) begin bad++;
      $display("FAIL fwd_rt_disabled got=%0d exp=0", alu_src2); end
    $display("test_forwarding: alu_src1=%0d alu_src2=%0d", alu_src1, alu_src2);
    clear_inputs();
  endtask

  task automatic test_load_use;
    MemReadE = 1; WriteRegE = 4'd4; rtD = 4'd4; use_rtD = 0; #1;
    total++; if (ctrl !== C_RUN) begin bad++;
      $display("FAIL lu_unused_src got=%b exp=%b", ctrl, C_RUN); end
    use_rtD = 0; WriteRegE = 4'd3; rsD = 4'd3; use_rsD = 1; #1;
    total++; if (ctrl !== C_STALL) begin bad++;
      $display("FAIL lu_detect got=%b exp=%b", ctrl, C_STALL); end
    tick(); clear_inputs(); #1;
    total++; if (ctrl !== C_STALL) begin bad++;
      $display("FAIL lu_bubble2 got=%b exp=%b", ctrl, C_STALL); end
    tick();
    total++; if (ctrl !== C_RUN) begin bad++;
      $display("FAIL lu_release got=%b exp=%b", ctrl, C_RUN); end
    total++; if (stall_count !== 16'd2) begin bad++;
      $display("FAIL lu_count got=%0d exp=2", stall_count); end
    $display("test_load_use: ctrl=%b stall_count=%0d", ctrl, stall_count);
  endtask

  task automatic test_branch_override;
    MemReadE = 1; WriteRegE = 4'd3; rsD = 4'd3; use_rsD = 1; PCSrc = 1; #1;
    total++; if (ctrl !== C_BRANCH) begin bad++;
      $display("FAIL br_override got=%b exp=%b", ctrl, C_BRANCH); end
    tick(); clear_inputs(); #1;
    total++; if (ctrl !== C_RUN) begin bad++;
      $display("FAIL br_no_bubble got=%b exp=%b", ctrl, C_RUN); end
    total++; if (stall_count !== 16'd2) begin bad++;
      $display("FAIL br_count got=%0d exp=2", stall_count); end
    $display("test_branch_override: ctrl=%b stall_count=%0d", ctrl, stall_count);
  endtask

  task automatic test_jump;
    jump = 1; #1;
    total++; if (ctrl !== C_JUMP) begin bad++;
      $display("FAIL jump_only got=%b exp=%b", ctrl, C_JUMP); end
    MemReadE = 1; WriteRegE = 4'd6; rtD = 4'd6; use_rtD = 1; #1;
    total++; if (ctrl !== C_STALL) begin bad++;
      $display("FAIL jump_vs_stall got=%b exp=%b", ctrl, C_STALL); end
    tick(); MemReadE = 0; use_rtD = 0; #1;
    total++; if (ctrl !== C_STALL) begin bad++;
      $display("FAIL jump_stall2 got=%b exp=%b", ctrl, C_STALL); end
    tick();
    total++; if (ctrl !== C_JUMP) begin bad++;
      $display("FAIL jump_reeval got=%b exp=%b", ctrl, C_JUMP); end
    total++; if (stall_count !== 16'd4) begin bad++;
      $display("FAIL jump_count got=%0d exp=4", stall_count); end
    $display("test_jump: ctrl=%b stall_count=%0d", ctrl, stall_count);
    clear_inputs();
  endtask

  task automatic test_drain_restart;
    stop_req = 1; PCSrc = 1;
    tick(); PCSrc = 0; stop_req = 0; #1;
    total++; if (ctrl !== C_RUN) begin bad++;
      $display("FAIL stop_blocked got=%b exp=%b", ctrl, C_RUN); end
    stop_req = 1;
    tick(); stop_req = 0; start = 1; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (ctrl !== C_DRAIN) begin bad++;
        $display("FAIL drain_cycle%0d got=%b exp=%b", i, ctrl, C_DRAIN); end
      tick();
    end
    start = 0; #1;
    total++; if (ctrl !== C_STOPPED) begin bad++;
      $display("FAIL stopped got=%b exp=%b", ctrl, C_STOPPED); end
    start = 1;
    tick(); start = 0; #1;
    total++; if (ctrl !== C_RUN) begin bad++;
      $display("FAIL restart got=%b exp=%b", ctrl, C_RUN); end
    total++; if (stall_count !== 16'd4) begin bad++;
      $display("FAIL restart_count got=%0d exp=4", stall_count); end
    $display("test_drain_restart: ctrl=%b stall_count=%0d", ctrl, stall_count);
  endtask

  task automatic test_reset_mid_drain;
    stop_req = 1;
    tick(); stop_req = 0; #1;
    total++; if (ctrl !== C_DRAIN) begin bad++;
      $display("FAIL rdrain_enter got=%b exp=%b", ctrl, C_DRAIN); end
    tick();
    rst = 0;
    tick(); rst = 1; #1;
    total++; if (ctrl !== C_IDLE) begin bad++;
      $display("FAIL rdrain_idle got=%b exp=%b", ctrl, C_IDLE); end
    total++; if (stall_count !== 16'd0) begin bad++;
      $display("FAIL rdrain_count got=%0d exp=0", stall_count); end
    $display("test_reset_mid_drain: ctrl=%b stall_count=%0d", ctrl, stall_count);
  endtask

  initial begin
    test_reset();
    test_start();
    test_forwarding();
    test_load_use();
    test_branch_override();
    test_jump();
    test_drain_restart();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
